// File: rtl/drp_arbiter.sv
// Round-robin arbiter sharing one DRP among NREQ requesters, one buffered op each.
// Optional macro DRP_TIMEOUT_EN adds a drp_rdy wait limit of TIMEOUT_CYCLES.
module drp_arbiter #(
    parameter int NREQ           = 2,
    parameter int DRP_ADDR_WIDTH = 9,
    parameter int DRP_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NREQ-1:0]                  req_en,
    input  logic [NREQ-1:0]                  req_we,
    input  logic [NREQ*DRP_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NREQ*DRP_DATA_WIDTH-1:0]   req_di,
    output logic [NREQ-1:0]                  req_busy,
    output logic [NREQ-1:0]                  req_rdy,
    output logic [DRP_DATA_WIDTH-1:0]        req_do,
    output logic [NREQ-1:0]                  req_err,
    output logic [NREQ-1:0]                  req_timeout,
    output logic                             drp_en,
    output logic                             drp_we,
    output logic [DRP_ADDR_WIDTH-1:0]        drp_addr,
    output logic [DRP_DATA_WIDTH-1:0]        drp_di,
    input  logic                             drp_rdy,
    input  logic [DRP_DATA_WIDTH-1:0]        drp_do
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    if (NREQ < 1 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("drp_arbiter: unsupported parameter value");
    end

    state_t                    state;
    logic [IW-1:0]             gnt;
    logic [IW-1:0]             rr;
    logic [NREQ-1:0]           gnt_oh;
    logic [NREQ-1:0]           slot_vld;
    logic [NREQ-1:0]           slot_we;
    logic [DRP_ADDR_WIDTH-1:0] slot_addr [NREQ];
    logic [DRP_DATA_WIDTH-1:0] slot_di   [NREQ];
    logic [IW-1:0]             pick;
    logic                      pick_vld;
    logic                      op_done;
    logic                      op_tout;
    logic [NREQ-1:0]           slot_clr;

    assign req_busy = slot_vld;
    assign op_done  = (state == S_WAIT) && drp_rdy;
    assign slot_clr = (op_done || op_tout) ? gnt_oh : '0;

    // First pending slot strictly after rr, wrapping; smallest distance wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick     = '0;
        pick_vld = 1'b0;
        gnt_oh   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(rr) + k) % NREQ;
            if (slot_vld[idx]) begin
                pick     = IW'(idx);
                pick_vld = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            gnt_oh[i] = (IW'(i) == gnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            slot_vld <= '0;
            req_err  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                req_err[i] <= req_en[i] && slot_vld[i];
                if (req_en[i] && !slot_vld[i]) begin
                    slot_vld[i] <= 1'b1;
                end else if (slot_clr[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: payload registers carry no reset; slot_vld alone decides whether they are used.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (req_en[i] && !slot_vld[i]) begin
                slot_we[i]   <= req_we[i];
                slot_addr[i] <= req_addr[i*DRP_ADDR_WIDTH +: DRP_ADDR_WIDTH];
                slot_di[i]   <= req_di[i*DRP_DATA_WIDTH +: DRP_DATA_WIDTH];
            end
        end
    end

    // DRP strobes are loaded on the IDLE->ISSUE edge so they are high during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            gnt      <= '0;
            rr       <= IW'(NREQ - 1);
            drp_en   <= 1'b0;
            drp_we   <= 1'b0;
            drp_addr <= '0;
            drp_di   <= '0;
            req_rdy  <= '0;
            req_do   <= '0;
        end else begin
            drp_en  <= 1'b0;
            drp_we  <= 1'b0;
            req_rdy <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gnt      <= pick;
                        rr       <= pick;
                        drp_en   <= 1'b1;
                        drp_we   <= slot_we[pick];
                        drp_addr <= slot_addr[pick];
                        drp_di   <= slot_di[pick];
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (op_done) begin
                        req_rdy <= gnt_oh;
                        req_do  <= slot_we[gnt] ? slot_di[gnt] : drp_do;
                        state   <= S_IDLE;
                    end else if (op_tout) begin
                        req_rdy <= gnt_oh;
                        req_do  <= '1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DRP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    assign op_tout = (state == S_WAIT) && !drp_rdy && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            req_timeout <= '0;
        end else begin
            req_timeout <= op_tout ? gnt_oh : '0;
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !op_done) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign op_tout     = 1'b0;
    assign req_timeout = '0;
`endif

endmodule

// File: tb/tb_drp_arbiter.sv
// Directed self-checking bench for drp_arbiter (NREQ=2, 9-bit addr, 16-bit data).
// Timeout scenario runs only when DRP_TIMEOUT_EN is defined for the build.
module tb_drp_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 9;
    localparam int DW   = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_en = '0;
    logic [NREQ-1:0]      req_we = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_di = '0;
    logic [NREQ-1:0]      req_busy;
    logic [NREQ-1:0]      req_rdy;
    logic [DW-1:0]        req_do;
    logic [NREQ-1:0]      req_err;
    logic [NREQ-1:0]      req_timeout;
    logic                 drp_en;
    logic                 drp_we;
    logic [AW-1:0]        drp_addr;
    logic [DW-1:0]        drp_di;
    logic                 drp_rdy = 1'b0;
    logic [DW-1:0]        drp_do = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    drp_arbiter #(
        .NREQ(NREQ), .DRP_ADDR_WIDTH(AW), .DRP_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_en(req_en), .req_we(req_we), .req_addr(req_addr), .req_di(req_di),
        .req_busy(req_busy), .req_rdy(req_rdy), .req_do(req_do),
        .req_err(req_err), .req_timeout(req_timeout),
        .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_di(drp_di),
        .drp_rdy(drp_rdy), .drp_do(drp_do)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] di);
        req_en[i]             = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = addr;
        req_di[i*DW +: DW]    = di;
    endtask

    task automatic do_reset;
        req_en  = '0;
        drp_rdy = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_en(input int limit);
        int waited;
        waited = 0;
        while (!drp_en && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    initial begin
        int en_cnt;
        logic [AW-1:0] exp_addr;

        // Reset state
        tick();
        tick();
        check("rst_busy", req_busy, 0);
        check("rst_rdy", req_rdy, 0);
        check("rst_do", req_do, 0);
        check("rst_err", req_err, 0);
        check("rst_tout", req_timeout, 0);
        check("rst_drp_en", drp_en, 0);
        check("rst_drp_we", drp_we, 0);
        check("rst_drp_addr", drp_addr, 0);
        check("rst_drp_di", drp_di, 0);
        rst_n = 1'b1;
        tick();

        // Spurious drp_rdy while IDLE
        drp_rdy = 1'b1;
        drp_do  = 16'h5555;
        tick();
        drp_rdy = 1'b0;
        check("idle_spur_rdy", req_rdy, 0);
        tick();
        check("idle_spur_en", drp_en, 0);

        // 1: single read, drp_rdy 3 cycles after drp_en, spurious rdy in ISSUE
        set_req(0, 1'b0, 9'h008, 16'h0000);
        tick();                                  // cycle 1
        req_en = '0;
        check("t1_busy", req_busy, 2'b01);
        check("t1_en_c1", drp_en, 0);
        tick();                                  // cycle 2
        check("t1_en_c2", drp_en, 1);
        check("t1_addr", drp_addr, 9'h008);
        check("t1_we", drp_we, 0);
        drp_rdy = 1'b1;
        drp_do  = 16'hDEAD;
        tick();                                  // cycle 3
        drp_rdy = 1'b0;
        check("t1_en_c3", drp_en, 0);
        check("t1_issue_spur", req_rdy, 0);
        tick();                                  // cycle 4
        tick();                                  // cycle 5
        check("t1_rdy_early", req_rdy, 0);
        drp_rdy = 1'b1;
        drp_do  = 16'hBEEF;
        tick();                                  // cycle 6
        drp_rdy = 1'b0;
        check("t1_rdy", req_rdy, 2'b01);
        check("t1_do", req_do, 16'hBEEF);
        check("t1_busy_clr", req_busy, 0);
        tick();
        check("t1_rdy_pulse", req_rdy, 0);
        check("t1_tout", req_timeout, 0);

        // 2: simultaneous write (req0) and read (req1)
        do_reset();
        set_req(0, 1'b1, 9'h010, 16'h1234);
        set_req(1, 1'b0, 9'h020, 16'h0000);
        tick();                                  // cycle 1
        req_en = '0;
        check("t2_busy", req_busy, 2'b11);
        tick();                                  // cycle 2
        check("t2_en0", drp_en, 1);
        check("t2_addr0", drp_addr, 9'h010);
        check("t2_we0", drp_we, 1);
        check("t2_di0", drp_di, 16'h1234);
        tick();                                  // cycle 3
        check("t2_we_drop", drp_we, 0);
        drp_rdy = 1'b1;
        drp_do  = 16'h0BAD;
        tick();                                  // cycle 4
        drp_rdy = 1'b0;
        check("t2_rdy0", req_rdy, 2'b01);
        check("t2_do0", req_do, 16'h1234);
        check("t2_busy0", req_busy, 2'b10);
        tick();                                  // cycle 5
        check("t2_en1", drp_en, 1);
        check("t2_addr1", drp_addr, 9'h020);
        check("t2_we1", drp_we, 0);
        tick();                                  // cycle 6
        drp_rdy = 1'b1;
        drp_do  = 16'hA5A5;
        tick();                                  // cycle 7
        drp_rdy = 1'b0;
        check("t2_rdy1", req_rdy, 2'b10);
        check("t2_do1", req_do, 16'hA5A5);
        check("t2_busy1", req_busy, 0);

        // 3: round-robin with re-strobe on every req_rdy
        do_reset();
        set_req(0, 1'b0, 9'h030, 16'h0000);
        set_req(1, 1'b0, 9'h031, 16'h0000);
        tick();
        req_en = '0;
        for (int op = 0; op < 8; op++) begin
            exp_addr = AW'(32'h30 + op % 2);
            wait_en(10);
            check("t3_en", drp_en, 1);
            check("t3_gnt", drp_addr, exp_addr);
            tick();
            drp_rdy = 1'b1;
            drp_do  = DW'(op);
            tick();
            drp_rdy = 1'b0;
            check("t3_rdy", req_rdy, 32'(1) << (op % 2));
            check("t3_do", req_do, DW'(op));
            if (op < 6) set_req(op % 2, 1'b0, exp_addr, 16'h0000);
            tick();
            req_en = '0;
        end
        tick();
        check("t3_busy_end", req_busy, 0);

        // 4: overrun on requester 1
        do_reset();
        set_req(1, 1'b0, 9'h044, 16'h0000);
        tick();                                  // cycle 1
        check("t4_busy", req_busy, 2'b10);
        check("t4_err_c1", req_err, 0);
        set_req(1, 1'b1, 9'h055, 16'hFFFF);
        tick();                                  // cycle 2
        req_en = '0;
        check("t4_err", req_err, 2'b10);
        check("t4_en", drp_en, 1);
        check("t4_addr", drp_addr, 9'h044);
        check("t4_we", drp_we, 0);
        tick();                                  // cycle 3
        check("t4_err_pulse", req_err, 0);
        drp_rdy = 1'b1;
        drp_do  = 16'h0044;
        tick();                                  // cycle 4
        drp_rdy = 1'b0;
        check("t4_rdy", req_rdy, 2'b10);
        check("t4_do", req_do, 16'h0044);
        en_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            en_cnt += int'(drp_en);
        end
        check("t4_no_reissue", en_cnt, 0);
        check("t4_busy_end", req_busy, 0);

`ifdef DRP_TIMEOUT_EN
        // 5: timeout after 16 WAIT cycles, then normal op
        do_reset();
        set_req(0, 1'b0, 9'h00C, 16'h0000);
        tick();                                  // cycle 1
        req_en = '0;
        tick();                                  // cycle 2
        check("t5_en", drp_en, 1);
        for (int c = 0; c < 16; c++) tick();     // cycle 18
        check("t5_rdy_early", req_rdy, 0);
        check("t5_tout_early", req_timeout, 0);
        tick();                                  // cycle 19
        check("t5_rdy", req_rdy, 2'b01);
        check("t5_tout", req_timeout, 2'b01);
        check("t5_do", req_do, 16'hFFFF);
        check("t5_busy", req_busy, 0);
        set_req(0, 1'b0, 9'h00D, 16'h0000);
        tick();
        req_en = '0;
        tick();
        check("t5_en2", drp_en, 1);
        check("t5_addr2", drp_addr, 9'h00D);
        tick();
        drp_rdy = 1'b1;
        drp_do  = 16'h1111;
        tick();
        drp_rdy = 1'b0;
        check("t5_rdy2", req_rdy, 2'b01);
        check("t5_tout2", req_timeout, 0);
        check("t5_do2", req_do, 16'h1111);
`endif

        // 6: reset while in WAIT, late drp_rdy ignored
        do_reset();
        set_req(0, 1'b0, 9'h01F, 16'h0000);
        tick();                                  // cycle 1
        req_en = '0;
        tick();                                  // cycle 2
        tick();                                  // cycle 3 (WAIT)
        check("t6_busy_pre", req_busy, 2'b01);
        rst_n = 1'b0;
        #1;
        check("t6_busy_rst", req_busy, 0);
        check("t6_en_rst", drp_en, 0);
        check("t6_addr_rst", drp_addr, 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("t6_rdy_rst", req_rdy, 0);
        check("t6_do_rst", req_do, 0);
        drp_rdy = 1'b1;
        drp_do  = 16'h7777;
        tick();
        drp_rdy = 1'b0;
        check("t6_late_rdy", req_rdy, 0);
        check("t6_late_do", req_do, 0);
        check("t6_busy_post", req_busy, 0);
        tick();
        check("t6_en_post", drp_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
